chip8_fetch: RTL and testbench

Read master for the CHIP-8 program/font memory. It drives the memory's 12-bit address and consumes the 8-bit registered read data, which returns one cycle after the address is sampled. It serves two request types from the core: a 16-bit big-endian opcode fetch at PC, and an N-byte burst from I for DXYN sprite rows and FX65 register loads. Bursts are pipelined to one byte per cycle, with no bubbles after the first byte returns.

---
 rtl/chip8_pkg.sv | 22 ++
 rtl/chip8_rd_pipe.sv | 37 +++
 rtl/chip8_fetch.sv | 170 +++++++++++++++++
 tb/tb_chip8_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 memory fetch path.
package chip8_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    localparam logic [11:0] FONT_BASE   = 12'h000;
    localparam int unsigned FONT_STRIDE = 5;
    localparam logic [11:0] PROG_BASE   = 12'h200;

    localparam logic FETCH_OP    = 1'b0;
    localparam logic FETCH_BURST = 1'b1;

    typedef logic [15:0] opcode_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/chip8_rd_pipe.sv
// Two-stage valid/index/last shift register matching the memory read latency.
module chip8_rd_pipe #(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    logic [1:0]       valid_q;
    logic [1:0]       last_q;
    logic [IDX_W-1:0] idx_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            idx_q[0] <= '0;
            idx_q[1] <= '0;
        end else begin
            valid_q  <= {valid_q[0], in_valid};
            last_q   <= {last_q[0], in_valid & in_last};
            idx_q[0] <= in_idx;
            idx_q[1] <= idx_q[0];
        end
    end

    assign out_valid = valid_q[1];
    assign out_last  = last_q[1];
    assign out_idx   = idx_q[1];

endmodule

// File: rtl/chip8_fetch.sv
// Read master for CHIP-8 program/font memory: opcode fetches and pipelined bursts.
// Optional range checking is built when CHIP8_FETCH_FAULT_EN is defined.
module chip8_fetch #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_mode,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output chip8_pkg::opcode_t  opcode,
    output logic                opcode_valid,
    output logic [DATA_W-1:0]   byte_data,
    output logic [3:0]          byte_idx,
    output logic                byte_valid,
    output logic                done,
    output logic                fault
);

    import chip8_pkg::*;

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [LEN_W-1:0]  count_q, issued_q, req_count;
    logic              mode_q;
    logic [DATA_W-1:0] hi_q;
    logic              busy_q, done_q, opcode_valid_q, byte_valid_q;
    logic [DATA_W-1:0] byte_data_q;
    logic [3:0]        byte_idx_q;
    opcode_t           opcode_q;

    logic       accept, zero_burst, issue_more, finish;
    logic       pipe_in_valid, pipe_in_last, pipe_valid, pipe_last;
    logic [3:0] pipe_in_idx, pipe_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && !zero_burst) state_d = StIssue;
            StIssue: if (!issue_more) state_d = StDrain;
            StDrain: if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accept        = (state_q == StIdle) && req_valid;
        zero_burst    = (req_mode == FETCH_BURST) && (req_len == '0);
        req_count     = (req_mode == FETCH_BURST) ? req_len : LEN_W'(2);
        issue_more    = (state_q == StIssue) && (issued_q < count_q);
        pipe_in_valid = (accept && !zero_burst) || issue_more;
        pipe_in_idx   = accept ? 4'd0 : issued_q[3:0];
        pipe_in_last  = accept ? (req_count == LEN_W'(1))
                               : (LEN_W'(issued_q + 1'b1) == count_q);
        finish        = pipe_valid && pipe_last;
    end

    chip8_rd_pipe #(
        .IDX_W(4)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_in_valid),
        .in_idx    (pipe_in_idx),
        .in_last   (pipe_in_last),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx),
        .out_last  (pipe_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q     <= '0;
            count_q        <= '0;
            issued_q       <= '0;
            mode_q         <= FETCH_OP;
            hi_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            opcode_valid_q <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= '0;
            byte_idx_q     <= '0;
            opcode_q       <= '0;
        end else begin
            if (accept && !zero_burst) begin
                mem_addr_q <= req_addr;
                count_q    <= req_count;
                issued_q   <= LEN_W'(1);
                mode_q     <= req_mode;
            end else if (issue_more) begin
                mem_addr_q <= mem_addr_q + 1'b1;
                issued_q   <= issued_q + 1'b1;
            end

            // busy stays up through the done cycle even though the FSM is already idle
            if (accept)      busy_q <= 1'b1;
            else if (done_q) busy_q <= 1'b0;

            done_q         <= finish || (accept && zero_burst);
            opcode_valid_q <= finish && (mode_q == FETCH_OP);
            byte_valid_q   <= pipe_valid && (mode_q == FETCH_BURST);

            if (pipe_valid && (mode_q == FETCH_BURST)) begin
                byte_data_q <= mem_data;
                byte_idx_q  <= pipe_idx;
            end
            if (pipe_valid && (mode_q == FETCH_OP)) begin
                if (pipe_last) opcode_q <= {hi_q, mem_data};
                else           hi_q     <= mem_data;
            end
        end
    end

`ifdef CHIP8_FETCH_FAULT_EN
    logic              fault_q, fault_pend_q, req_bad;
    logic [ADDR_W:0]   burst_end;

    always_comb begin
        burst_end = {1'b0, req_addr} + (ADDR_W + 1)'(req_len);
        if (req_mode == FETCH_OP) begin
            req_bad = req_addr[0] || (req_addr == '1);
        end else begin
            // range addr..addr+len-1 crosses the top when the end exceeds 2^ADDR_W
            req_bad = burst_end[ADDR_W] && (burst_end[ADDR_W-1:0] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
        end else if (accept) begin
            fault_q      <= zero_burst ? 1'b0 : 1'b0;
            fault_pend_q <= zero_burst ? 1'b0 : req_bad;
        end else if (finish) begin
            fault_q      <= fault_pend_q;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign busy         = busy_q;
    assign mem_addr     = mem_addr_q;
    assign opcode       = opcode_q;
    assign opcode_valid = opcode_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_idx     = byte_idx_q;
    assign byte_valid   = byte_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Self-checking bench for chip8_fetch: per-cycle behavioural model plus directed literal checks.
module tb_chip8_fetch;

    localparam int MAXC = 2000;

    logic        clk, rst;
    logic        req_valid, req_mode;
    logic [11:0] req_addr;
    logic [4:0]  req_len;
    logic        busy, opcode_valid, byte_valid, done, fault;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data, byte_data;
    logic [3:0]  byte_idx;
    logic [15:0] opcode;

    chip8_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .byte_data    (byte_data),
        .byte_idx     (byte_idx),
        .byte_valid   (byte_valid),
        .done         (done),
        .fault        (fault)
    );

    logic [7:0] mem [4096];
    logic [7:0] font [80];

    always @(posedge clk) mem_data <= mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int free_edge = 0;

    logic        exp_busy [MAXC];
    logic        exp_done [MAXC];
    logic        exp_ov   [MAXC];
    logic        exp_bv   [MAXC];
    logic [7:0]  exp_bd   [MAXC];
    logic [3:0]  exp_bi   [MAXC];
    logic [11:0] exp_addr [MAXC];
    logic [15:0] exp_op   [MAXC];
    logic        exp_flt  [MAXC];

    logic [7:0] got_bytes [$];

    function automatic void cmp(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void hold_addr(input int from, input logic [11:0] v);
        for (int i = from; i < MAXC; i++) exp_addr[i] = v;
    endfunction

    function automatic void hold_op(input int from, input logic [15:0] v);
        for (int i = from; i < MAXC; i++) exp_op[i] = v;
    endfunction

    function automatic void hold_flt(input int from, input logic v);
        for (int i = from; i < MAXC; i++) exp_flt[i] = v;
    endfunction

    function automatic void model_reset(input int e);
        for (int i = e; i < MAXC; i++) begin
            exp_busy[i] = 0; exp_done[i] = 0; exp_ov[i] = 0; exp_bv[i] = 0;
            exp_addr[i] = 0; exp_op[i] = 0; exp_flt[i] = 0;
        end
    endfunction

    // Expected outputs of a request accepted at edge e0, from the documented timing rules.
    function automatic void model_accept(input int e0, input logic mode, input logic [11:0] a,
                                         input logic [4:0] len);
        int last;
        int cnt;
        logic bad;
        cnt = (mode == 1'b0) ? 2 : int'(len);
        hold_flt(e0, 1'b0);
        if (mode == 1'b1 && len == 0) begin
            exp_done[e0] = 1;
            exp_busy[e0] = 1;
            free_edge = e0 + 1;
            return;
        end
        for (int k = 0; k < cnt; k++) hold_addr(e0 + k, 12'(a + k));
        if (mode == 1'b0) begin
            last = e0 + 3;
            exp_ov[last] = 1;
            hold_op(last, {mem[a], mem[12'(a + 1)]});
            bad = a[0] || (a == 12'hFFF);
        end else begin
            for (int k = 0; k < cnt; k++) begin
                exp_bv[e0 + 2 + k] = 1;
                exp_bd[e0 + 2 + k] = mem[12'(a + k)];
                exp_bi[e0 + 2 + k] = 4'(k);
            end
            last = e0 + cnt + 1;
            bad = (int'(a) + cnt) > 4096;
        end
        exp_done[last] = 1;
        for (int i = e0; i <= last; i++) exp_busy[i] = 1;
        free_edge = last + 1;
`ifdef CHIP8_FETCH_FAULT_EN
        hold_flt(last, bad);
`else
        bad = 1'b0;
        hold_flt(last, bad);
`endif
    endfunction

    always @(posedge clk) begin
        int e;
        e = cyc + 1;
        if (e < MAXC) begin
            if (rst) begin
                model_reset(e);
                free_edge = e + 1;
            end else if (req_valid && e >= free_edge) begin
                model_accept(e, req_mode, req_addr, req_len);
            end
        end
        cyc = e;
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            cmp("busy",         32'(busy),         32'(exp_busy[cyc]));
            cmp("mem_addr",     32'(mem_addr),     32'(exp_addr[cyc]));
            cmp("opcode",       32'(opcode),       32'(exp_op[cyc]));
            cmp("opcode_valid", 32'(opcode_valid), 32'(exp_ov[cyc]));
            cmp("byte_valid",   32'(byte_valid),   32'(exp_bv[cyc]));
            cmp("done",         32'(done),         32'(exp_done[cyc]));
            cmp("fault",        32'(fault),        32'(exp_flt[cyc]));
            if (exp_bv[cyc]) begin
                cmp("byte_data", 32'(byte_data), 32'(exp_bd[cyc]));
                cmp("byte_idx",  32'(byte_idx),  32'(exp_bi[cyc]));
            end
        end
        if (byte_valid === 1'b1) got_bytes.push_back(byte_data);
    end

    // Called at a negedge; returns the number of further negedges until done was seen.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL %s: done never seen, got done=%b, want 1", tag, done);
        end
    endtask

    task automatic start_req(input logic mode, input logic [11:0] a, input logic [4:0] len);
        got_bytes.delete();
        req_mode  = mode;
        req_addr  = a;
        req_len   = len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic exp_fault3;
        rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_addr = '0; req_len = '0;
        font = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
                 8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
                 8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
                 8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
                 8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
                 8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
                 8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
                 8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80};
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 80; i++) mem[i] = font[i];
        for (int i = 5; i < 80; i++) mem[12'h050 + i - 5] = font[i];
        mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
        mem[12'h202] = 8'hA2; mem[12'h203] = 8'h2A;
        mem[12'hFFE] = 8'hAB; mem[12'hFFF] = 8'hCD;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp("reset busy",     32'(busy),     32'h0);
        cmp("reset mem_addr", 32'(mem_addr), 32'h0);
        cmp("reset opcode",   32'(opcode),   32'h0);

        // 1: opcode fetch from the program base
        start_req(1'b0, 12'h200, 5'd0);
        wait_done("op200", n);
        cmp("op200 latency", 32'(n), 32'd3);
        cmp("op200 opcode", 32'(opcode), 32'h00E0);
        @(negedge clk);

        // 2: font glyph 0
        start_req(1'b1, 12'h000, 5'd5);
        wait_done("glyph0", n);
        cmp("glyph0 latency", 32'(n), 32'd6);
        @(negedge clk);
        cmp("glyph0 count", 32'(got_bytes.size()), 32'd5);
        if (got_bytes.size() == 5) begin
            cmp("glyph0 b0", 32'(got_bytes[0]), 32'hF0);
            cmp("glyph0 b1", 32'(got_bytes[1]), 32'h90);
            cmp("glyph0 b4", 32'(got_bytes[4]), 32'hF0);
        end

        // 3: burst wrapping past the top of memory
        start_req(1'b1, 12'hFFE, 5'd4);
        cmp("wrap addr0", 32'(mem_addr), 32'hFFE);
        @(negedge clk); cmp("wrap addr1", 32'(mem_addr), 32'hFFF);
        @(negedge clk); cmp("wrap addr2", 32'(mem_addr), 32'h000);
        @(negedge clk); cmp("wrap addr3", 32'(mem_addr), 32'h001);
        wait_done("wrap", n);
`ifdef CHIP8_FETCH_FAULT_EN
        exp_fault3 = 1'b1;
`else
        exp_fault3 = 1'b0;
`endif
        cmp("wrap fault", 32'(fault), 32'(exp_fault3));
        @(negedge clk);
        cmp("wrap count", 32'(got_bytes.size()), 32'd4);
        if (got_bytes.size() == 4) begin
            cmp("wrap b0", 32'(got_bytes[0]), 32'hAB);
            cmp("wrap b1", 32'(got_bytes[1]), 32'hCD);
            cmp("wrap b2", 32'(got_bytes[2]), 32'hF0);
            cmp("wrap b3", 32'(got_bytes[3]), 32'h90);
        end

        // 4: zero-length burst
        start_req(1'b1, 12'h123, 5'd0);
        cmp("len0 done", 32'(done), 32'h1);
        cmp("len0 mem_addr", 32'(mem_addr), 32'h001);
        repeat (3) @(negedge clk);

        // 5: req_valid held through a 16-byte burst; an opcode fetch follows back-to-back
        got_bytes.delete();
        req_mode = 1'b1; req_addr = 12'h050; req_len = 5'd16; req_valid = 1'b1;
        @(negedge clk);
        wait_done("held", n);
        req_mode = 1'b0; req_addr = 12'h200;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done("b2b op", n);
        cmp("b2b latency", 32'(n), 32'd3);
        cmp("held count", 32'(got_bytes.size()), 32'd16);
        if (got_bytes.size() == 16) begin
            cmp("held b0", 32'(got_bytes[0]), 32'h20);
            cmp("held b1", 32'(got_bytes[1]), 32'h60);
            cmp("held b4", 32'(got_bytes[4]), 32'h70);
        end
        @(negedge clk);

        // 6: reset during byte 2 of an 8-byte burst, then a clean opcode fetch
        start_req(1'b1, 12'h000, 5'd8);
        repeat (4) @(negedge clk);
        cmp("pre-reset byte_valid", 32'(byte_valid), 32'h1);
        cmp("pre-reset byte_idx",   32'(byte_idx),   32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("post-reset byte_valid", 32'(byte_valid), 32'h0);
        cmp("post-reset busy",       32'(busy),       32'h0);
        repeat (12) @(negedge clk);
        start_req(1'b0, 12'h202, 5'd0);
        wait_done("op202", n);
        cmp("op202 opcode", 32'(opcode), 32'hA22A);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
